// File: rtl/wiz_bus_pkg.sv
// rtl/wiz_bus_pkg.sv - shared state encoding and timing-counter sizing for the WIZ bus bridge
package wiz_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } wiz_state_t;

    // The down-counter only ever holds (phase length - 1), so log2 of the longest phase is enough.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/wiz_int_sync.sv
// rtl/wiz_int_sync.sv - two-flop synchronizer turning the async active-low interrupt into an active-high flag
module wiz_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic int_n,
    output logic irq
);

    logic meta;

    // Invert at the first stage so both flops carry the active-high sense.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            irq  <= 1'b0;
        end else begin
            meta <= ~int_n;
            irq  <= meta;
        end
    end

endmodule

// File: rtl/wiz_bus_bridge.sv
// rtl/wiz_bus_bridge.sv - slave-port to asynchronous SRAM-style WIZ chip bus bridge with fixed access timing
module wiz_bus_bridge
    import wiz_bus_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 3,
    parameter int T_HOLD   = 1,
    parameter int T_TURN   = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   AVS_ADDRESS,
    input  logic                AVS_CHIPSELECT,
    input  logic                AVS_READ,
    input  logic                AVS_WRITE,
    input  logic [DATA_W-1:0]   AVS_WRITEDATA,
    input  logic [DATA_W/8-1:0] AVS_BYTEENABLE,
    output logic [DATA_W-1:0]   AVS_READDATA,
    output logic                AVS_WAITREQUEST,
    output logic [ADDR_W-1:0]   WIZ_A,
    output logic [DATA_W-1:0]   WIZ_D_OUT,
    output logic                WIZ_D_OE,
    input  logic [DATA_W-1:0]   WIZ_D_IN,
    output logic                WIZ_CS_N,
    output logic                WIZ_RD_N,
    output logic                WIZ_WR_N,
    input  logic                WIZ_INT_N,
    output logic                IRQ,
    output logic                BE_ERR
);

    localparam int CW = cnt_width(T_SETUP, T_STROBE, T_HOLD, T_TURN);

    if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_TURN < 1) begin : g_bad_timing
        $error("wiz_bus_bridge: every timing parameter must be at least 1");
    end
    if (DATA_W != 8 && DATA_W != 16) begin : g_bad_width
        $error("wiz_bus_bridge: DATA_W must be 8 or 16");
    end

    wiz_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          cs_n_d, rd_n_d, wr_n_d, oe_d, waitreq_d, active, last;
    logic          req, legal, accept, err_acc;

    // A request is only taken while waitrequest is high, so an error ack cycle never re-accepts it.
    assign req     = AVS_CHIPSELECT && (AVS_READ || AVS_WRITE);
    assign legal   = (AVS_READ != AVS_WRITE) && (&AVS_BYTEENABLE);
    assign accept  = (state_q == ST_IDLE) && req && legal && AVS_WAITREQUEST;
    assign err_acc = (state_q == ST_IDLE) && req && !legal && AVS_WAITREQUEST;
    assign last    = (cnt_q == '0);

    // Next state, phase counter and next values of every registered bus strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (last) begin
                    state_d = ST_STROBE;
                    cnt_d   = CW'(T_STROBE - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (last) begin
                    state_d = ST_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (last) begin
                    state_d = ST_TURN;
                    cnt_d   = CW'(T_TURN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (last) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        wr_d      = accept ? AVS_WRITE : wr_q;
        active    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d    = !active;
        rd_n_d    = !((state_d == ST_STROBE) && !wr_d);
        wr_n_d    = !((state_d == ST_STROBE) && wr_d);
        oe_d      = active && wr_d;
        waitreq_d = !(((state_d == ST_HOLD) && (cnt_d == '0)) || err_acc);
    end

    // State register plus flopped strobes, so the chip only ever sees glitch-free edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wr_q            <= 1'b0;
            WIZ_CS_N        <= 1'b1;
            WIZ_RD_N        <= 1'b1;
            WIZ_WR_N        <= 1'b1;
            WIZ_D_OE        <= 1'b0;
            AVS_WAITREQUEST <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_q            <= wr_d;
            WIZ_CS_N        <= cs_n_d;
            WIZ_RD_N        <= rd_n_d;
            WIZ_WR_N        <= wr_n_d;
            WIZ_D_OE        <= oe_d;
            AVS_WAITREQUEST <= waitreq_d;
        end
    end

    // Address/data latch at accept, read capture at the end of the strobe, sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WIZ_A        <= '0;
            WIZ_D_OUT    <= '0;
            AVS_READDATA <= '0;
            BE_ERR       <= 1'b0;
        end else begin
            if (accept) begin
                WIZ_A <= AVS_ADDRESS;
                if (AVS_WRITE) WIZ_D_OUT <= AVS_WRITEDATA;
            end
            if (err_acc) begin
                BE_ERR       <= 1'b1;
                AVS_READDATA <= '0;
            end
            if ((state_q == ST_STROBE) && last && !wr_q) AVS_READDATA <= WIZ_D_IN;
        end
    end

    wiz_int_sync u_int_sync (
        .clk   (CLK),
        .rst   (RST),
        .int_n (WIZ_INT_N),
        .irq   (IRQ)
    );

endmodule

// File: tb/tb_wiz_bus_bridge.sv
// tb/tb_wiz_bus_bridge.sv - scoreboard bench for the WIZ bus bridge, default and 8-bit configurations
module tb_wiz_bus_bridge;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [9:0]  AVS_ADDRESS;
    logic        AVS_CHIPSELECT, AVS_READ, AVS_WRITE;
    logic [15:0] AVS_WRITEDATA;
    logic [1:0]  AVS_BYTEENABLE;
    logic [15:0] AVS_READDATA;
    logic        AVS_WAITREQUEST;
    logic [9:0]  WIZ_A;
    logic [15:0] WIZ_D_OUT, WIZ_D_IN;
    logic        WIZ_D_OE, WIZ_CS_N, WIZ_RD_N, WIZ_WR_N, WIZ_INT_N, IRQ, BE_ERR;

    logic [9:0]  addr8, a8;
    logic        cs8, rd8, wr8, waitreq8, oe8, cs_n8, rd_n8, wr_n8, int_n8, irq8, be_err8;
    logic [7:0]  wdata8, rdata8, d_out8, d_in8;
    logic [0:0]  be8;

    wiz_bus_bridge dut (
        .CLK(CLK), .RST(RST),
        .AVS_ADDRESS(AVS_ADDRESS), .AVS_CHIPSELECT(AVS_CHIPSELECT), .AVS_READ(AVS_READ),
        .AVS_WRITE(AVS_WRITE), .AVS_WRITEDATA(AVS_WRITEDATA), .AVS_BYTEENABLE(AVS_BYTEENABLE),
        .AVS_READDATA(AVS_READDATA), .AVS_WAITREQUEST(AVS_WAITREQUEST),
        .WIZ_A(WIZ_A), .WIZ_D_OUT(WIZ_D_OUT), .WIZ_D_OE(WIZ_D_OE), .WIZ_D_IN(WIZ_D_IN),
        .WIZ_CS_N(WIZ_CS_N), .WIZ_RD_N(WIZ_RD_N), .WIZ_WR_N(WIZ_WR_N), .WIZ_INT_N(WIZ_INT_N),
        .IRQ(IRQ), .BE_ERR(BE_ERR)
    );

    wiz_bus_bridge #(.DATA_W(8), .T_SETUP(2), .T_STROBE(1), .T_HOLD(2)) dut8 (
        .CLK(CLK), .RST(RST),
        .AVS_ADDRESS(addr8), .AVS_CHIPSELECT(cs8), .AVS_READ(rd8),
        .AVS_WRITE(wr8), .AVS_WRITEDATA(wdata8), .AVS_BYTEENABLE(be8),
        .AVS_READDATA(rdata8), .AVS_WAITREQUEST(waitreq8),
        .WIZ_A(a8), .WIZ_D_OUT(d_out8), .WIZ_D_OE(oe8), .WIZ_D_IN(d_in8),
        .WIZ_CS_N(cs_n8), .WIZ_RD_N(rd_n8), .WIZ_WR_N(wr_n8), .WIZ_INT_N(int_n8),
        .IRQ(irq8), .BE_ERR(be_err8)
    );

    typedef struct {
        int          cyc;
        int          cs;
        int          wr;
        int          rd;
        int          oe;
        logic [15:0] rdata;
        logic        be;
        logic        legal;
        logic        w;
        logic [9:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errs = 0;
    int          cyc = 0;
    int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    int          idle_from = 0;
    logic [15:0] last_rd = '0;
    logic        be_sticky = 1'b0;
    logic [15:0] dev_data = '0;
    logic [7:0]  dev_data8 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Chip model: drives read data only while the read strobe is low, junk otherwise.
    always @(negedge CLK) begin
        WIZ_D_IN = !WIZ_RD_N ? dev_data : 16'hBAD0;
        d_in8    = !rd_n8 ? dev_data8 : 8'h00;
    end

    // Monitor: measures strobe widths per access and checks each acknowledge against the scoreboard.
    always @(negedge CLK) begin
        if (RST || WIZ_CS_N) begin
            cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; oe_cnt = 0;
        end else begin
            cs_cnt++;
            if (!WIZ_WR_N) wr_cnt++;
            if (!WIZ_RD_N) rd_cnt++;
            if (WIZ_D_OE) oe_cnt++;
        end
        if (!RST && !AVS_WAITREQUEST) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_ack: ack at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_cycle", cyc, mon_e.cyc);
                chk("cs_low_cycles", cs_cnt, mon_e.cs);
                chk("wr_low_cycles", wr_cnt, mon_e.wr);
                chk("rd_low_cycles", rd_cnt, mon_e.rd);
                chk("oe_cycles", oe_cnt, mon_e.oe);
                chk("readdata", AVS_READDATA, mon_e.rdata);
                chk("be_err", BE_ERR, mon_e.be);
                if (mon_e.legal) chk("wiz_a", WIZ_A, mon_e.a);
                if (mon_e.w) chk("wiz_d_out", WIZ_D_OUT, mon_e.d);
            end
        end
    end

    task automatic access(input bit w, input bit r, input logic [9:0] addr,
                          input logic [15:0] wd, input logic [1:0] be, input logic [15:0] din);
        exp_t e;
        int   eff;
        int   t;
        bit   legal;
        legal   = (w != r) && (be == 2'b11);
        eff     = (cyc > idle_from) ? cyc : idle_from;
        e.legal = legal;
        e.w     = legal && w;
        e.a     = addr;
        e.d     = wd;
        if (legal) begin
            e.cyc = eff + 5;
            e.cs  = 5;
            e.wr  = w ? 3 : 0;
            e.rd  = r ? 3 : 0;
            e.oe  = w ? 5 : 0;
            if (r) last_rd = din;
            idle_from = e.cyc + 2;
        end else begin
            e.cyc = eff + 1;
            e.cs = 0; e.wr = 0; e.rd = 0; e.oe = 0;
            last_rd   = '0;
            be_sticky = 1'b1;
            idle_from = e.cyc + 1;
        end
        e.rdata = last_rd;
        e.be    = be_sticky;
        sb.push_back(e);
        dev_data       = din;
        AVS_ADDRESS    = addr;
        AVS_WRITEDATA  = wd;
        AVS_BYTEENABLE = be;
        AVS_WRITE      = w;
        AVS_READ       = r;
        AVS_CHIPSELECT = 1'b1;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (AVS_WAITREQUEST && t < 40);
        if (AVS_WAITREQUEST) begin
            checks++;
            errs++;
            $display("FAIL ack_timeout: no ack for address %0h within 40 cycles", addr);
            sb.delete();
        end
        @(posedge CLK);
        #1;
        AVS_CHIPSELECT = 1'b0;
        AVS_READ       = 1'b0;
        AVS_WRITE      = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cs_n"}, WIZ_CS_N, 1);
        chk({tag, "_rd_n"}, WIZ_RD_N, 1);
        chk({tag, "_wr_n"}, WIZ_WR_N, 1);
        chk({tag, "_d_oe"}, WIZ_D_OE, 0);
        chk({tag, "_waitreq"}, AVS_WAITREQUEST, 1);
        chk({tag, "_readdata"}, AVS_READDATA, 0);
        chk({tag, "_wiz_a"}, WIZ_A, 0);
        chk({tag, "_d_out"}, WIZ_D_OUT, 0);
        chk({tag, "_irq"}, IRQ, 0);
        chk({tag, "_be_err"}, BE_ERR, 0);
    endtask

    task automatic read8(input logic [9:0] addr, input logic [7:0] din);
        int t0;
        int t;
        dev_data8 = din;
        addr8 = addr; rd8 = 1'b1; cs8 = 1'b1;
        t0 = cyc;
        t  = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (waitreq8 && t < 40);
        chk("dut8_latency", cyc - t0, 5);
        chk("dut8_readdata", rdata8, din);
        chk("dut8_oe", oe8, 0);
        @(posedge CLK);
        #1;
        cs8 = 1'b0; rd8 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        RST = 1'b1;
        AVS_ADDRESS = '0; AVS_CHIPSELECT = 1'b0; AVS_READ = 1'b0; AVS_WRITE = 1'b0;
        AVS_WRITEDATA = '0; AVS_BYTEENABLE = 2'b11; WIZ_INT_N = 1'b1;
        addr8 = '0; cs8 = 1'b0; rd8 = 1'b0; wr8 = 1'b0; wdata8 = '0; be8 = 1'b1; int_n8 = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_state("reset");
        chk("reset_dut8_cs_n", cs_n8, 1);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Write then read held back-to-back, then more data patterns.
        access(1, 0, 10'h204, 16'hA55A, 2'b11, 16'h0000);
        access(0, 1, 10'h3FF, 16'h0000, 2'b11, 16'h1234);
        access(0, 1, 10'h000, 16'h0000, 2'b11, 16'hFFFF);
        access(1, 0, 10'h155, 16'h0001, 2'b11, 16'h0000);
        access(1, 0, 10'h2AA, 16'hFFFF, 2'b11, 16'h0000);

        // Illegal requests: partial byteenable, then read and write together.
        access(1, 0, 10'h100, 16'h7777, 2'b01, 16'h0000);
        access(1, 1, 10'h101, 16'h7777, 2'b11, 16'h0000);
        access(0, 1, 10'h0F0, 16'h0000, 2'b11, 16'h5AA5);
        access(0, 1, 10'h0F1, 16'h0000, 2'b10, 16'h0000);

        // Reset during the second strobe cycle of a write aborts it without an ack.
        AVS_ADDRESS = 10'h0AA; AVS_WRITEDATA = 16'h5555; AVS_BYTEENABLE = 2'b11;
        AVS_WRITE = 1'b1; AVS_READ = 1'b0; AVS_CHIPSELECT = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("wr_n_before_reset", WIZ_WR_N, 0);
        RST = 1'b1;
        AVS_CHIPSELECT = 1'b0; AVS_WRITE = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_state("abort");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        be_sticky = 1'b0;
        last_rd   = '0;
        idle_from = 0;
        @(posedge CLK);
        #1;
        access(1, 0, 10'h3C3, 16'hC33C, 2'b11, 16'h0000);
        access(0, 1, 10'h3C3, 16'h0000, 2'b11, 16'h8001);

        // Interrupt synchronizer latency and release.
        WIZ_INT_N = 1'b0;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!IRQ && t < 6);
        chk("irq_asserted", IRQ, 1);
        chk("irq_latency_in_range", ((t - 1) >= 2) && ((t - 1) <= 3), 1);
        @(posedge CLK);
        #1;
        WIZ_INT_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("irq_released", IRQ, 0);

        // 8-bit instance with stretched setup and hold.
        read8(10'h155, 8'hC3);
        read8(10'h2AA, 8'h3C);

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
